// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider datapath.
//   DIV_W       : default operand/result width, also used by the operand registers
//   div_state_e : divider FSM states
package div_pkg;
  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2,
    ERR  = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_iter_unit_if.sv
// Request/result bundle between the operand side and the divider engine.
//   start, x, y        : request and operands (driven by master)
//   busy, done, dbz, q, r : status and results (driven by slave / engine)
interface div_iter_unit_if import div_pkg::*; #(parameter int W = DIV_W);
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] q;
  logic [W-1:0] r;

  modport master (output start, x, y, input busy, done, dbz, q, r);
  modport slave  (input start, x, y, output busy, done, dbz, q, r);
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step (combinational).
//   rem_i  : partial remainder, W+1 bits
//   msb_i  : dividend bit shifted into the remainder LSB
//   div_i  : divisor
//   rem_o  : next partial remainder
//   qbit_o : quotient bit produced by this step
module div_step import div_pkg::*; #(parameter int W = DIV_W) (
  input  logic [W:0]   rem_i,
  input  logic         msb_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);
  logic [W:0] shifted, trial;

  always_comb begin
    shifted = {rem_i[W-1:0], msb_i};
    trial   = shifted - {1'b0, div_i};
    // A set rem MSB means the true shifted value exceeds 2^W > divisor,
    // so the subtract must succeed. Cannot happen while rem < divisor,
    // but keeps the step correct for any input.
    qbit_o  = rem_i[W] | ~trial[W];
    rem_o   = qbit_o ? trial : shifted;
  end
endmodule

// File: rtl/div_iter_unit.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of div_iter_unit_if (start/x/y in, busy/done/dbz/q/r out)
// Latency: W+1 cycles from accepted start to done; 1 cycle for divide-by-zero.
module div_iter_unit import div_pkg::*; #(parameter int W = DIV_W) (
  input  logic          clk,
  input  logic          rst_n,
  div_iter_unit_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  div_state_e   state_q;
  logic [W:0]   rem_q;
  logic [W-1:0] dq_q;   // dividend shifts out the top, quotient bits fill the bottom
  logic [W-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic         busy_q, done_q, dbz_q;
  logic [W-1:0] q_q, r_q;

  logic [W:0]   rem_d;
  logic         qbit_d;

  div_step #(.W(W)) u_step (
    .rem_i  (rem_q),
    .msb_i  (dq_q[W-1]),
    .div_i  (div_q),
    .rem_o  (rem_d),
    .qbit_o (qbit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dq_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          dq_q   <= bus.x;
          div_q  <= bus.y;
          rem_q  <= '0;
          cnt_q  <= '0;
          busy_q <= 1'b1;
          dbz_q  <= 1'b0;
          if (bus.y == '0) begin
            // Results are registered on entry so they are valid with done in ERR.
            state_q <= ERR;
            q_q     <= '1;
            r_q     <= bus.x;
            dbz_q   <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= ITER;
          end
        end
        ITER: begin
          rem_q <= rem_d;
          dq_q  <= {dq_q[W-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            state_q <= FIN;
            q_q     <= {dq_q[W-2:0], qbit_d};
            r_q     <= rem_d[W-1:0];
            done_q  <= 1'b1;
          end
        end
        FIN, ERR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_iter_unit_if #(.W(W)) bus ();

  div_iter_unit #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock; sample #1 after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one division; x/y are scrambled after acceptance to prove latching.
  task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output int lat);
    bus.start = 1'b1;
    bus.x     = x;
    bus.y     = y;
    step();
    bus.start = 1'b0;
    bus.x     = ~x;
    bus.y     = y + 4'd3;
    lat = 1;
    while (!bus.done && lat < 20) begin
      step();
      lat++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    q   = bus.q;
    r   = bus.r;
    dbz = bus.dbz;
    step();
  endtask

  logic [W-1:0] gq, gr;
  logic         gdbz;
  int           lat;

  typedef struct { logic [W-1:0] x, y, q, r; } vec_t;
  vec_t vecs[3] = '{'{4'd15, 4'd1, 4'd15, 4'd0},
                    '{4'd0,  4'd5, 4'd0,  4'd0},
                    '{4'd3,  4'd7, 4'd0,  4'd3}};

  initial begin
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;

    // reset state
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz",  bus.dbz,  0);
    chk("rst_q",    bus.q,    0);
    chk("rst_r",    bus.r,    0);
    step();
    rst_n = 1'b1;
    step();

    // 13/4 cycle by cycle: busy 1..5, done only at 5
    bus.start = 1'b1; bus.x = 4'd13; bus.y = 4'd4;
    for (int c = 0; c < 6; c++) begin
      step();
      bus.start = 1'b0; bus.x = 4'd2; bus.y = 4'd9;
      chk($sformatf("b13_busy_c%0d", c + 1), bus.busy, (c + 1 <= 5) ? 1 : 0);
      chk($sformatf("b13_done_c%0d", c + 1), bus.done, (c + 1 == 5) ? 1 : 0);
      if (c + 1 == 5) begin
        chk("b13_q",   bus.q,   3);
        chk("b13_r",   bus.r,   1);
        chk("b13_dbz", bus.dbz, 0);
      end
    end

    // directed vectors
    foreach (vecs[i]) begin
      do_div(vecs[i].x, vecs[i].y, gq, gr, gdbz, lat);
      chk($sformatf("v%0d_q", i),   gq,   vecs[i].q);
      chk($sformatf("v%0d_r", i),   gr,   vecs[i].r);
      chk($sformatf("v%0d_dbz", i), gdbz, 0);
      chk($sformatf("v%0d_lat", i), lat,  W + 1);
    end

    // divide by zero: done at cycle 1, busy low from cycle 2
    bus.start = 1'b1; bus.x = 4'd7; bus.y = 4'd0;
    step();
    bus.start = 1'b0;
    chk("dbz_done_c1", bus.done, 1);
    chk("dbz_flag_c1", bus.dbz,  1);
    chk("dbz_q",       bus.q,    4'hF);
    chk("dbz_r",       bus.r,    7);
    chk("dbz_busy_c1", bus.busy, 1);
    step();
    chk("dbz_busy_c2", bus.busy, 0);
    chk("dbz_done_c2", bus.done, 0);
    chk("dbz_hold",    bus.dbz,  1);

    // start re-pulsed mid-run (c2) and in FIN (c5); c6 accepted (14/3)
    for (int c = 0; c < 12; c++) begin
      bus.start = (c == 0 || c == 2 || c == 5 || c == 6);
      case (c)
        0:       begin bus.x = 4'd13; bus.y = 4'd4; end
        2:       begin bus.x = 4'd9;  bus.y = 4'd2; end
        5:       begin bus.x = 4'd1;  bus.y = 4'd1; end
        6:       begin bus.x = 4'd14; bus.y = 4'd3; end
        default: begin bus.x = 4'd0;  bus.y = 4'd0; end
      endcase
      step();
      chk($sformatf("rp_done_c%0d", c + 1), bus.done, (c + 1 == 5 || c + 1 == 11) ? 1 : 0);
      if (c + 1 == 5) begin
        chk("rp1_q", bus.q, 3);
        chk("rp1_r", bus.r, 1);
      end
      if (c + 1 == 11) begin
        chk("rp2_q", bus.q, 4);
        chk("rp2_r", bus.r, 2);
      end
    end
    bus.start = 1'b0;
    step();

    // reset in cycle 3 of a run
    bus.start = 1'b1; bus.x = 4'd13; bus.y = 4'd4;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_q",    bus.q,    0);
    chk("mr_r",    bus.r,    0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("mr_nodone_%0d", c), bus.done, 0);
    end
    rst_n = 1'b1;
    step();
    do_div(4'd13, 4'd4, gq, gr, gdbz, lat);
    chk("mr_after_q", gq, 3);
    chk("mr_after_r", gr, 1);

    // exhaustive sweep
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        do_div(xi[W-1:0], yi[W-1:0], gq, gr, gdbz, lat);
        if (yi == 0) begin
          chk($sformatf("sw_q_%0d_%0d", xi, yi), gq, 4'hF);
          chk($sformatf("sw_r_%0d_%0d", xi, yi), gr, xi);
          chk($sformatf("sw_z_%0d_%0d", xi, yi), gdbz, 1);
        end else begin
          chk($sformatf("sw_q_%0d_%0d", xi, yi), gq, xi / yi);
          chk($sformatf("sw_r_%0d_%0d", xi, yi), gr, xi % yi);
          chk($sformatf("sw_z_%0d_%0d", xi, yi), gdbz, 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
